// File: rtl/micropro_32bit.sv
// Single-cycle R-type execution core: 32x32 register file, one ALU op per clock,
// registered result/invalid outputs. No fetch, memory or branch logic.
module micropro_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] result,
  output logic        invalid
);

  logic [6:0]  funct7;
  logic [4:0]  rs2;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [6:0]  opcode;

  assign funct7 = instr[31:25];
  assign rs2    = instr[24:20];
  assign rs1    = instr[19:15];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign opcode = instr[6:0];

  logic [31:0] regs [32];
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu;
  logic        ok;

  // x0 reads as zero regardless of storage contents.
  assign op_a  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign op_b  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign shamt = op_b[4:0];

  always_comb begin
    alu = 32'd0;
    ok  = 1'b0;
    if (funct7 == 7'b0000000) begin
      unique case (opcode)
        7'b0000001: begin
          ok = (funct3 == 3'b000) || (funct3 == 3'b001);
          alu = (funct3 == 3'b001) ? (op_a - op_b) : (op_a + op_b);
        end
        7'b0000011: begin
          ok = 1'b1;
          case (funct3)
            3'b000:  alu = op_a << shamt;
            3'b001:  alu = op_a >> shamt;
            3'b010:  alu = $unsigned($signed(op_a) >>> shamt);
            default: ok  = 1'b0;
          endcase
        end
        7'b0000111: begin
          ok = 1'b1;
          case (funct3)
            3'b000:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
            3'b001:  alu = {31'd0, op_a < op_b};
            default: ok  = 1'b0;
          endcase
        end
        7'b0001111: begin
          ok = 1'b1;
          case (funct3)
            3'b000:  alu = op_a ^ op_b;
            3'b001:  alu = op_a | op_b;
            3'b010:  alu = op_a & op_b;
            default: ok  = 1'b0;
          endcase
        end
        default: ok = 1'b0;
      endcase
    end
  end

  // Reset preloads x[i] = i so operands are meaningful without a load path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (ok && (rd != 5'd0)) begin
      regs[rd] <= alu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= 32'd0;
      invalid <= 1'b0;
    end else begin
      invalid <= ~ok;
      if (ok) result <= alu;
    end
  end

endmodule

// File: tb/tb_micropro_32bit.sv
// Scoreboard bench for micropro_32bit: driver pushes model predictions, monitor
// pops one per executed clock edge and compares {invalid, result}.
module tb_micropro_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] result;
  logic        invalid;

  micropro_32bit dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .result  (result),
    .invalid (invalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] INV_OP = 32'h0000007F;

  // reference model state
  logic [31:0] mreg [32];
  logic [31:0] m_res;
  logic        m_inv;

  // scoreboard
  logic [32:0] exp_q [$];
  string       tag_q [$];
  int          checks;
  int          errors;

  function automatic logic [31:0] enc(input logic [6:0] f7, input int b, input int a,
                                      input logic [2:0] f3, input int d, input logic [6:0] op);
    logic [4:0] r2, r1, rdd;
    r2 = 5'(b); r1 = 5'(a); rdd = 5'(d);
    return {f7, r2, r1, f3, rdd, op};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
    m_res = 32'd0;
    m_inv = 1'b0;
  endtask

  // Executes one instruction on the architectural model.
  task automatic model_exec(input logic [31:0] ins);
    logic [31:0] a, b, v;
    logic        good;
    int          sh;
    a = mreg[ins[19:15]];
    b = mreg[ins[24:20]];
    sh = int'(b % 32);
    good = 1'b1;
    v = 32'd0;
    if (ins[31:25] != 7'd0) good = 1'b0;
    else begin
      case ({ins[6:0], ins[14:12]})
        {7'h01, 3'd0}: v = a + b;
        {7'h01, 3'd1}: v = a - b;
        {7'h03, 3'd0}: v = a << sh;
        {7'h03, 3'd1}: v = a >> sh;
        {7'h03, 3'd2}: v = $unsigned($signed(a) >>> sh);
        {7'h07, 3'd0}: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h07, 3'd1}: v = (a < b) ? 32'd1 : 32'd0;
        {7'h0F, 3'd0}: v = a ^ b;
        {7'h0F, 3'd1}: v = a | b;
        {7'h0F, 3'd2}: v = a & b;
        default:       good = 1'b0;
      endcase
    end
    m_inv = ~good;
    if (good) begin
      m_res = v;
      if (ins[11:7] != 5'd0) mreg[ins[11:7]] = v;
    end
  endtask

  // driver: one instruction per clock edge
  task automatic issue(input logic [31:0] ins, input string tag);
    @(negedge clk);
    instr = ins;
    model_exec(ins);
    exp_q.push_back({m_inv, m_res});
    tag_q.push_back(tag);
  endtask

  // Asynchronous reset away from any clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 32'd0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got invalid=%0b result=%h, want invalid=0 result=00000000",
               tag, invalid, result);
    end
    instr = INV_OP;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_exec(INV_OP);
    exp_q.push_back({m_inv, m_res});
    tag_q.push_back("post_reset");
  endtask

  // monitor: the DUT updates its outputs on every edge out of reset
  initial begin
    logic [32:0] e;
    string       t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if ({invalid, result} !== e) begin
          errors++;
          $display("FAIL %s: got invalid=%0b result=%h, want invalid=%0b result=%h",
                   t, invalid, result, e[32], e[31:0]);
        end
      end
    end
  end

  localparam logic [9:0] OPS [10] = '{
    {7'h01, 3'd0}, {7'h01, 3'd1}, {7'h03, 3'd0}, {7'h03, 3'd1}, {7'h03, 3'd2},
    {7'h07, 3'd0}, {7'h07, 3'd1}, {7'h0F, 3'd0}, {7'h0F, 3'd1}, {7'h0F, 3'd2}
  };

  initial begin
    logic [9:0]  sel;
    logic [31:0] ins;
    int          budget;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    instr  = INV_OP;
    model_reset();
    #12;
    checks++;
    if (result !== 32'd0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got invalid=%0b result=%h, want invalid=0 result=00000000",
               invalid, result);
    end
    @(negedge clk);
    instr = enc(7'd0, 1, 0, 3'd0, 8, 7'h01);
    rst   = 1'b0;
    model_exec(instr);
    exp_q.push_back({m_inv, m_res});
    tag_q.push_back("add_first");

    issue(enc(7'd0, 1, 0, 3'd1, 9, 7'h01),  "sub");
    issue(enc(7'd0, 3, 2, 3'd0, 10, 7'h03), "sll");
    issue(enc(7'd0, 3, 2, 3'd1, 14, 7'h03), "srl");
    issue(enc(7'd0, 3, 2, 3'd2, 15, 7'h03), "sra");
    issue(enc(7'd0, 5, 4, 3'd0, 11, 7'h07), "slt");
    issue(enc(7'd0, 5, 4, 3'd1, 12, 7'h07), "sltu");
    issue(enc(7'd0, 1, 9, 3'd0, 18, 7'h07), "slt_neg");
    issue(enc(7'd0, 1, 9, 3'd1, 19, 7'h07), "sltu_big");
    issue(enc(7'd0, 1, 0, 3'd0, 13, 7'h0F), "xor");
    issue(enc(7'd0, 1, 0, 3'd1, 16, 7'h0F), "or");
    issue(enc(7'd0, 1, 0, 3'd2, 17, 7'h0F), "and");
    issue(enc(7'd0, 0, 13, 3'd0, 21, 7'h01), "rb_x13");
    issue(enc(7'd0, 0, 16, 3'd0, 22, 7'h01), "rb_x16");
    issue(enc(7'd0, 0, 17, 3'd0, 23, 7'h01), "rb_x17");
    issue(enc(7'd0, 0, 8, 3'd0, 24, 7'h01),  "rb_x8");
    issue(enc(7'd0, 0, 9, 3'd0, 25, 7'h01),  "rb_x9");
    issue(INV_OP,                            "illegal_op");
    issue(enc(7'd1, 1, 2, 3'd0, 20, 7'h01),  "funct7_bad");
    issue(enc(7'd0, 0, 20, 3'd0, 26, 7'h01), "rb_x20");
    issue(enc(7'd0, 2, 1, 3'd0, 0, 7'h01),   "write_x0");
    issue(enc(7'd0, 0, 0, 3'd0, 27, 7'h01),  "rb_x0");
    issue(enc(7'd0, 3, 3, 3'd0, 3, 7'h01),   "rd_eq_rs");
    issue(enc(7'd0, 0, 3, 3'd0, 28, 7'h01),  "rb_x3");
    issue(enc(7'd0, 1, 2, 3'd3, 5, 7'h03),   "bad_funct3");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) ins = $urandom();
      else begin
        sel = OPS[$urandom_range(0, 9)];
        ins = enc(7'd0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  sel[2:0], int'($urandom_range(0, 31)), sel[9:3]);
      end
      issue(ins, "random");
    end

    issue(enc(7'd0, 2, 1, 3'd0, 8, 7'h01), "pre_reset");
    async_reset("async_reset");
    issue(enc(7'd0, 0, 8, 3'd0, 1, 7'h01), "rb_x8_reset");
    issue(enc(7'd0, 0, 31, 3'd0, 2, 7'h01), "rb_x31_reset");

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micropro_32bit.md
Name: micropro_32bit

Overview:
Single-cycle 32-bit register-register ALU micro-processor. Decodes one R-type instruction per clock, reads two operands from an internal 32x32 register file, executes the ALU op, writes the result back to the register file and presents it on a registered output port. Used as a standalone execution core; there is no fetch, memory or branch logic.

Parameters:
none (data width fixed at 32, register count fixed at 32)

Ports:
clk      input   1   rising-edge clock
rst      input   1   asynchronous active-high reset
instr    input   32  instruction, sampled on each rising clk edge
result   output  32  registered ALU result of last valid instruction
invalid  output  1   registered flag, 1 when last sampled instruction was unsupported

Behaviour:
- Instruction fields: funct7=instr[31:25], rs2=instr[24:20], rs1=instr[19:15], funct3=instr[14:12], rd=instr[11:7], opcode=instr[6:0].
- Supported ops (funct7 must be 7'b0000000):
  - opcode 0000001: funct3 000 ADD rs1+rs2; 001 SUB rs1-rs2 (mod 2^32).
  - opcode 0000011: funct3 000 SLL rs1<<rs2[4:0]; 001 SRL logical right by rs2[4:0]; 010 SRA arithmetic right by rs2[4:0].
  - opcode 0000111: funct3 000 SLT signed rs1<rs2 -> 1 else 0; 001 SLTU unsigned compare, same encoding.
  - opcode 0001111: funct3 000 XOR; 001 OR; 010 AND.
- Any other opcode, funct3 or nonzero funct7 is invalid.
- Register file: 32 x 32-bit; combinational reads of rs1/rs2; synchronous write on rising clk.
- x0 hardwired to 0: reads return 0, writes discarded (result port still shows computed value).
- Reset (rst=1, asynchronous): x[i] <= i for i=0..31 (x0=0), result <= 0, invalid <= 0. Held while rst high; first instruction executes on first rising edge after rst deasserts.
- Latency: instruction stable before rising edge N -> result, invalid and rd write all update at edge N (one clock). Next instruction reads post-write register contents; back-to-back dependency needs no stall.
- Valid instruction: result <= ALU value, invalid <= 0, x[rd] <= ALU value (if rd!=0).
- Invalid instruction: invalid <= 1, result holds previous value, no register write.
- rs1==rs2, rd==rs1/rs2: operands are read before the write; the new value is visible next cycle.
- Shift amounts use only rs2[4:0]; upper bits ignored. SRA replicates bit 31.
- No overflow or carry flags; arithmetic wraps.

Test Plan:
- Reset, then ADD rd=8 rs1=0 rs2=1 (instr 0x00100401) -> result=1, invalid=0, x8=1.
- SUB rd=9 rs1=0 rs2=1 -> result=0xFFFFFFFF; then SLL rd=10 rs1=2 rs2=3 -> 16; SRL/SRA rd=14/15 same operands -> 0, 0.
- SLT rd=11 rs1=4 rs2=5 -> 1; SLTU rd=12 -> 1; SLT after SUB-produced x9 (0xFFFFFFFF) vs x1 -> 1 signed, SLTU -> 0.
- XOR/OR/AND rs1=0 rs2=1 into rd=13/16/17 -> 1, 1, 0; read back via ADD rdX + x0 confirms writeback.
- Illegal opcode 0x0000007F and funct7=0000001 ADD -> invalid=1, result unchanged, target rd unchanged; next valid op clears invalid.
- Write to rd=0 (ADD x0=x1+x2) -> result=3, subsequent read of x0 returns 0; assert rst mid-stream asynchronously -> result=0, invalid=0, x8 back to 8 immediately, without waiting for a clock edge.
